// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce.
//
// Drives one keypad row at a time and samples the synchronized column inputs
// once the row has settled. A single-column hit freezes the scan and is
// debounced. If the hit stays stable long enough, it is reported as an
// accepted key. The key is then tracked until a debounced release, after
// which scanning resumes on the next row.
//
// Ports
//   clk        single clock, rising-edge active
//   reset      synchronous, active-high
//   col_sync   [3:0] synchronized columns, 1 = pressed
//   row        [3:0] one-hot active-high row drive
//   key_code   [3:0] last accepted key {row_idx, col_idx}
//   key_valid  one-cycle pulse on key acceptance
//   key_held   high while an accepted key is held or release-debouncing
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_sync,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DWELL_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [DEB_W-1:0]   deb, deb_nxt;
  logic [3:0]         cand_col, cand_col_nxt;   // latched one-hot column
  logic [3:0]         cand_code, cand_code_nxt; // code of the key under debounce
  logic [3:0]         row_nxt;
  logic [3:0]         key_code_nxt;
  logic               key_valid_nxt;
  logic               key_held_nxt;

  // Index of the set bit in a one-hot nibble.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Advance the row drive 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  function automatic logic [3:0] next_row(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      dwell     <= '0;
      deb       <= '0;
      cand_col  <= 4'd0;
      cand_code <= 4'd0;
      row       <= 4'b0001;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      deb       <= deb_nxt;
      cand_col  <= cand_col_nxt;
      cand_code <= cand_code_nxt;
      row       <= row_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    dwell_nxt     = dwell;
    deb_nxt       = deb;
    cand_col_nxt  = cand_col;
    cand_code_nxt = cand_code;
    row_nxt       = row;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;

    case (state)
      ST_SCAN: begin
        // Columns are only trusted on the last dwell cycle, after the row settled.
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (is_onehot(col_sync)) begin
            state_nxt     = ST_DEBOUNCE;
            deb_nxt       = '0;
            cand_col_nxt  = col_sync;
            cand_code_nxt = {onehot_idx(row), onehot_idx(col_sync)};
          end else begin
            row_nxt = next_row(row);
          end
        end else begin
          dwell_nxt = dwell + DWELL_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (col_sync == cand_col) begin
          if (deb == DEB_LAST) begin
            state_nxt     = ST_HELD;
            deb_nxt       = '0;
            key_code_nxt  = cand_code;
            key_valid_nxt = 1'b1;
          end else begin
            deb_nxt = deb + DEB_W'(1);
          end
        end else begin
          state_nxt = ST_SCAN;
          row_nxt   = next_row(row);
          dwell_nxt = '0;
          deb_nxt   = '0;
        end
      end

      ST_HELD: begin
        // Only the latched column matters while held.
        if ((col_sync & cand_col) == 4'd0) begin
          state_nxt = ST_RELEASE;
          deb_nxt   = '0;
        end
      end

      ST_RELEASE: begin
        if ((col_sync & cand_col) != 4'd0) begin
          state_nxt = ST_HELD;
          deb_nxt   = '0;
        end else if (deb == DEB_LAST) begin
          state_nxt = ST_SCAN;
          row_nxt   = next_row(row);
          dwell_nxt = '0;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb + DEB_W'(1);
        end
      end

      default: begin
        state_nxt = ST_SCAN;
        row_nxt   = 4'b0001;
        dwell_nxt = '0;
        deb_nxt   = '0;
      end
    endcase

    key_held_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl.
// Stimulus pushes each expected key acceptance (absolute cycle, code) into a
// queue. An independent monitor pops an entry on every key_valid pulse and
// compares it against the pulse.
module tb_keypad_scan_ctrl;

  localparam int unsigned SCAN_CYCLES     = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_sync;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_sync (col_sync),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   c0        = 0;
  int   n_valid   = 0;
  int   exp_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, cyc - c0);
    end
  endtask

  // Advance to relative cycle rel (cycles counted from the last reset release).
  task automatic go_to(input int rel);
    while ((cyc - c0) < rel) @(negedge clk);
  endtask

  task automatic expect_key(input int rel, input logic [3:0] code);
    exp_t e;
    e.cyc  = 32'(c0 + rel);
    e.code = code;
    exp_q.push_back(e);
    exp_valid++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    col_sync = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_row", 32'(row), 32'h1);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    reset = 1'b0;
    c0    = cyc;
  endtask

  function automatic logic [3:0] row_at(input int rel);
    case ((rel / 4) % 4)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Monitor: every key_valid pulse must match the oldest expected acceptance.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (key_valid === 1'b1) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got pulse code %0h expected none (abs cycle %0d)", key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("valid_key_code", 32'(key_code), 32'(e.code));
        chk("valid_cycle", 32'(cyc), e.cyc);
        chk("valid_key_held", 32'(key_held), 32'h1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset    = 1'b1;
    col_sync = 4'd0;

    // Idle scan: rows rotate every 4 cycles, no key.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      go_to(i);
      chk("idle_row", 32'(row), 32'(row_at(i)));
    end
    chk("idle_key_held", 32'(key_held), 32'h0);

    // Press row 1 col 2: sample at rel 7, accept at rel 24, code 0110.
    do_reset();
    go_to(4);
    col_sync = 4'b0100;
    expect_key(24, 4'b0110);
    go_to(15);
    chk("deb_row_frozen", 32'(row), 32'h2);
    chk("deb_key_held", 32'(key_held), 32'h0);
    go_to(23);
    chk("pre_accept_held", 32'(key_held), 32'h0);
    go_to(24);
    chk("accept_held", 32'(key_held), 32'h1);
    go_to(30);
    chk("hold_held", 32'(key_held), 32'h1);
    col_sync = 4'd0;
    go_to(46);
    chk("release_held", 32'(key_held), 32'h1);
    go_to(47);
    chk("released_held", 32'(key_held), 32'h0);
    chk("released_row", 32'(row), 32'h4);
    chk("code_retained", 32'(key_code), 32'h6);
    go_to(51);
    chk("resume_row", 32'(row), 32'h8);

    // Row 3 col 0 with glitch at debounce count 8; then the returning column
    // is picked up on row 0 at rel 28 and accepted at rel 45 as code 0000.
    do_reset();
    go_to(12);
    col_sync = 4'b0001;
    go_to(23);
    chk("glitch_row_frozen", 32'(row), 32'h8);
    go_to(24);
    col_sync = 4'b0000;
    go_to(25);
    col_sync = 4'b0001;
    chk("glitch_row_next", 32'(row), 32'h1);
    chk("glitch_key_held", 32'(key_held), 32'h0);
    expect_key(45, 4'b0000);
    go_to(45);
    chk("repress_held", 32'(key_held), 32'h1);
    go_to(50);
    col_sync = 4'd0;
    go_to(66);
    chk("repress_release_held", 32'(key_held), 32'h1);
    go_to(67);
    chk("repress_released", 32'(key_held), 32'h0);
    chk("repress_row", 32'(row), 32'h2);

    // Row 2 col 3 held; 5-cycle drop, other columns toggle; then full release.
    do_reset();
    go_to(8);
    col_sync = 4'b1000;
    expect_key(28, 4'b1011);
    go_to(32);
    col_sync = 4'd0;
    go_to(34);
    chk("bounce_held", 32'(key_held), 32'h1);
    go_to(37);
    col_sync = 4'b1000;
    go_to(38);
    chk("bounce_back_held", 32'(key_held), 32'h1);
    go_to(40);
    col_sync = 4'b1111;
    go_to(43);
    chk("other_cols_held", 32'(key_held), 32'h1);
    chk("other_cols_row", 32'(row), 32'h4);
    go_to(44);
    col_sync = 4'd0;
    go_to(60);
    chk("full_release_held", 32'(key_held), 32'h1);
    go_to(61);
    chk("full_released", 32'(key_held), 32'h0);
    chk("full_released_row", 32'(row), 32'h8);
    chk("full_released_code", 32'(key_code), 32'hB);
    go_to(65);
    chk("full_resume_row", 32'(row), 32'h1);

    // Two columns at the sample point are ignored.
    do_reset();
    col_sync = 4'b0011;
    go_to(3);
    chk("multi_sample_row", 32'(row), 32'h1);
    go_to(4);
    chk("multi_ignored_row", 32'(row), 32'h2);
    chk("multi_key_held", 32'(key_held), 32'h0);
    go_to(8);
    chk("multi_row2", 32'(row), 32'h4);
    go_to(16);
    chk("multi_row_wrap", 32'(row), 32'h1);
    chk("multi_key_held_end", 32'(key_held), 32'h0);
    col_sync = 4'd0;

    // Reset while HELD, then reset while DEBOUNCE.
    do_reset();
    col_sync = 4'b0010;
    expect_key(20, 4'b0001);
    go_to(25);
    chk("pre_reset_held", 32'(key_held), 32'h1);
    reset    = 1'b1;
    col_sync = 4'd0;
    go_to(26);
    chk("held_reset_row", 32'(row), 32'h1);
    chk("held_reset_code", 32'(key_code), 32'h0);
    chk("held_reset_held", 32'(key_held), 32'h0);
    chk("held_reset_valid", 32'(key_valid), 32'h0);
    reset    = 1'b0;
    c0       = cyc;
    col_sync = 4'b0100;
    go_to(10);
    chk("deb_reset_row_frozen", 32'(row), 32'h1);
    reset = 1'b1;
    go_to(11);
    chk("deb_reset_row", 32'(row), 32'h1);
    chk("deb_reset_held", 32'(key_held), 32'h0);
    chk("deb_reset_code", 32'(key_code), 32'h0);
    reset    = 1'b0;
    c0       = cyc;
    col_sync = 4'd0;
    go_to(40);
    chk("post_reset_held", 32'(key_held), 32'h0);

    chk("pending_expects", 32'(exp_q.size()), 32'h0);
    chk("valid_count", 32'(n_valid), 32'(exp_valid));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
